// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed scan driver for a 2-digit common-anode
//            7-segment display. One shared segment bus and two anodes.
//            Each digit slot begins with a blanking interval to suppress
//            ghosting. Digit patterns are latched once per frame so a frame
//            never mixes old and new values.
// Ports    : clk        - system clock, posedge
//            reset      - asynchronous reset, active low
//            en         - scan enable; low parks the sequence with display dark
//            ones[7:0]  - ones-digit pattern, active low (a..g = bit7..1, dp = bit0)
//            tens[7:0]  - tens-digit pattern, same format
//            seg[7:0]   - shared segment bus, active low
//            an[1:0]    - anodes, active low; an[0] = ones, an[1] = tens
//            frame_tick - one-cycle pulse at the start of each scanned frame
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 50000,  // clk cycles per digit slot
  parameter int BLANK_CYC   = 16      // dark cycles at the start of each slot
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] ones,
  input  logic [7:0] tens,
  output logic [7:0] seg,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int SHOW_CYC = REFRESH_DIV - BLANK_CYC;
  localparam int CNT_W    = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);

  localparam logic [7:0] SEG_DARK = 8'hff;
  localparam logic [1:0] AN_DARK  = 2'b11;

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       sh_ones, sh_ones_nxt;
  logic [7:0]       sh_tens, sh_tens_nxt;
  logic [7:0]       seg_nxt;
  logic [1:0]       an_nxt;
  logic             tick_nxt;

  // State, counter, shadow and output registers. Outputs are registered
  // from the next-state decode so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BLANK0;
      cnt        <= '0;
      sh_ones    <= SEG_DARK;
      sh_tens    <= SEG_DARK;
      seg        <= SEG_DARK;
      an         <= AN_DARK;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sh_ones    <= sh_ones_nxt;
      sh_tens    <= sh_tens_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_tick <= tick_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 1'b1;
    sh_ones_nxt = sh_ones;
    sh_tens_nxt = sh_tens;
    seg_nxt     = SEG_DARK;
    an_nxt      = AN_DARK;
    tick_nxt    = 1'b0;

    if (!en) begin
      // Parked: dark, restart from the top of a frame when re-enabled.
      state_nxt = BLANK0;
      cnt_nxt   = '0;
    end else begin
      // The only capture point is the very first cycle of a frame.
      if (state == BLANK0 && cnt == '0) begin
        sh_ones_nxt = ones;
        sh_tens_nxt = tens;
      end

      case (state)
        BLANK0: if (cnt == BLANK_LAST) begin
          state_nxt = SHOW0;
          cnt_nxt   = '0;
        end
        SHOW0: if (cnt == SHOW_LAST) begin
          state_nxt = BLANK1;
          cnt_nxt   = '0;
        end
        BLANK1: if (cnt == BLANK_LAST) begin
          state_nxt = SHOW1;
          cnt_nxt   = '0;
        end
        SHOW1: if (cnt == SHOW_LAST) begin
          state_nxt = BLANK0;
          cnt_nxt   = '0;
          tick_nxt  = 1'b1;  // wrap into a new frame
        end
        default: begin
          state_nxt = BLANK0;
          cnt_nxt   = '0;
        end
      endcase

      // Use the post-capture shadow values so a one-cycle blank still
      // shows the freshly latched digit.
      case (state_nxt)
        SHOW0: begin
          an_nxt  = 2'b10;
          seg_nxt = sh_ones_nxt;
        end
        SHOW1: begin
          an_nxt  = 2'b01;
          seg_nxt = sh_tens_nxt;
        end
        default: begin
          an_nxt  = AN_DARK;
          seg_nxt = SEG_DARK;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver (REFRESH_DIV=8,
//            BLANK_CYC=2). A frame-position model predicts seg/an/frame_tick
//            every cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int RD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 2 * RD;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] ones, tens;
  logic [7:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ones       (ones),
    .tens       (tens),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model: position within the frame ----------
  int         m_pos  = 0;
  logic [7:0] m_ones = 8'hff;
  logic [7:0] m_tens = 8'hff;
  logic       m_tick = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pos  <= 0;
      m_ones <= 8'hff;
      m_tens <= 8'hff;
      m_tick <= 1'b0;
    end else if (!en) begin
      m_pos  <= 0;
      m_tick <= 1'b0;
    end else begin
      if (m_pos == 0) begin
        m_ones <= ones;
        m_tens <= tens;
      end
      m_pos  <= (m_pos + 1) % FRAME;
      m_tick <= (m_pos == FRAME - 1);
    end
  end

  function automatic logic [1:0] exp_an(int p);
    if (p >= BC && p < RD)      return 2'b10;
    if (p >= RD + BC)           return 2'b01;
    return 2'b11;
  endfunction

  function automatic logic [7:0] exp_seg(int p, logic [7:0] o, logic [7:0] t);
    if (p >= BC && p < RD)      return o;
    if (p >= RD + BC)           return t;
    return 8'hff;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle model comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_an",   32'(an),         32'(exp_an(m_pos)));
      chk("model_seg",  32'(seg),        32'(exp_seg(m_pos, m_ones, m_tens)));
      chk("model_tick", 32'(frame_tick), 32'(m_tick));
      chk("no_overlap", 32'(an != 2'b00), 32'(1));
    end
  end

  // Advance n posedges, then settle 2 time units past the edge.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    ones  = 8'h03;
    tens  = 8'h9f;
    #1 reset = 1'b0;
    chk_on = 1'b1;

    // Reset held while clocking: dark throughout.
    for (int i = 0; i < 4; i++) begin
      edges(1);
      chk("rst_an", 32'(an), 32'h3);
      chk("rst_seg", 32'(seg), 32'hff);
      chk("rst_tick", 32'(frame_tick), 32'h0);
    end

    // Basic scan.
    ones = 8'h25;
    tens = 8'h9f;
    @(negedge clk) reset = 1'b1;
    edges(1);  chk("e1_an", 32'(an), 32'h3);
    edges(1);  chk("e2_an", 32'(an), 32'h2);  chk("e2_seg", 32'(seg), 32'h25);
    edges(2);  ones = 8'h99;                   // edge 4: change mid-frame
    edges(3);  chk("e7_seg", 32'(seg), 32'h25);
    edges(1);  chk("e8_an", 32'(an), 32'h3);  chk("e8_seg", 32'(seg), 32'hff);
    edges(2);  chk("e10_an", 32'(an), 32'h1); chk("e10_seg", 32'(seg), 32'h9f);
    edges(6);  chk("e16_tick", 32'(frame_tick), 32'h1); chk("e16_an", 32'(an), 32'h3);
    edges(1);  chk("e17_tick", 32'(frame_tick), 32'h0);
    edges(1);  chk("e18_seg", 32'(seg), 32'h99); chk("e18_an", 32'(an), 32'h2);

    // Enable drop during SHOW1 of the second frame (edge 28).
    ones = 8'h25;
    edges(10);
    chk("e28_an", 32'(an), 32'h1);
    en = 1'b0;
    edges(1);  chk("dis_an", 32'(an), 32'h3); chk("dis_seg", 32'(seg), 32'hff);
    chk("dis_tick", 32'(frame_tick), 32'h0);
    edges(3);  chk("dis_hold_an", 32'(an), 32'h3);
    en = 1'b1;
    edges(1);  chk("reen_blank", 32'(an), 32'h3);
    edges(1);  chk("reen_show", 32'(an), 32'h2); chk("reen_seg", 32'(seg), 32'h25);
    for (int i = 0; i < 5; i++) begin
      edges(1);
      chk("reen_show_n", 32'(an), 32'h2);
    end
    edges(1);  chk("reen_end", 32'(an), 32'h3);

    // Async reset mid-SHOW0 of the next frame.
    edges(10);
    chk("pre_rst_an", 32'(an), 32'h2);
    tens = 8'hff;
    #1 reset = 1'b0;
    #1;
    chk("async_an", 32'(an), 32'h3);
    chk("async_seg", 32'(seg), 32'hff);
    @(negedge clk) reset = 1'b1;
    edges(10);
    chk("post_rst_an", 32'(an), 32'h1);
    chk("post_rst_seg", 32'(seg), 32'hff);

    // Chained-counter style: counter at 12, a couple of frames.
    ones = 8'h25;
    tens = 8'h9f;
    edges(2 * FRAME);

    // Randomized phase: patterns, enable drops, occasional async reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) ones = 8'($urandom);
      if ($urandom_range(0, 3) == 0) tens = 8'($urandom);
      if ($urandom_range(0, 19) == 0)      en = 1'b0;
      else if ($urandom_range(0, 2) == 0)  en = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b0;
        #2 reset = 1'b1;
      end
      edges(1);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
